// File: rtl/cache_refill_arbiter.sv
// Round-robin refill arbiter: shares one memory read port among N_PORTS cache miss ports,
// with one block in flight and a one-entry block buffer that serves repeat misses.
module cache_refill_arbiter #(
  parameter int unsigned N_PORTS     = 4,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned BLOCK_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            i_req_valid,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] i_req_addr,
  output logic [N_PORTS-1:0]            o_req_ready,
  output logic [BLOCK_WIDTH-1:0]        o_req_data,
  output logic                          o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]         o_mem_req_addr,
  input  logic                          i_mem_req_ready,
  input  logic                          i_mem_resp_valid,
  input  logic [BLOCK_WIDTH-1:0]        i_mem_resp_data
);

  localparam int unsigned IdW = $clog2(N_PORTS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_GRANT, S_HOLD} state_t;

  state_t                 r_state, w_state_nxt;
  logic [IdW-1:0]         r_gid, r_rr_ptr, w_win_id;
  logic                   w_win_found, w_hit, w_grant;
  logic [ADDR_WIDTH-1:0]  r_saved_addr, r_buf_addr, w_win_addr, w_gid_addr;
  logic [BLOCK_WIDTH-1:0] r_buf_data;
  logic                   r_buf_valid;

  // Scan from the highest offset down so the port nearest rr_ptr is assigned last and wins.
  always_comb begin
    int idx;
    logic [IdW-1:0] w_idx;
    idx         = 0;
    w_idx       = '0;
    w_win_found = 1'b0;
    w_win_id    = '0;
    for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
      idx   = (int'(r_rr_ptr) + k) % int'(N_PORTS);
      w_idx = IdW'(idx);
      if (i_req_valid[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end

  assign w_win_addr = i_req_addr[int'(w_win_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_gid_addr = i_req_addr[int'(r_gid)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_hit      = r_buf_valid && (w_win_addr == r_buf_addr);
  assign w_grant    = (r_state == S_GRANT) && i_req_valid[r_gid] && (w_gid_addr == r_saved_addr);

  always_comb begin
    w_state_nxt     = r_state;
    o_req_ready     = '0;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_win_found) w_state_nxt = w_hit ? S_GRANT : S_REQ;
      end
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = r_saved_addr;
        if (i_mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_resp_valid) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        o_req_ready[r_gid] = w_grant;
        // An abandoned or re-addressed request drops back to arbitration; buffer is kept.
        w_state_nxt = w_grant ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_req_data = r_buf_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_gid        <= '0;
      r_rr_ptr     <= '0;
      r_saved_addr <= '0;
      r_buf_addr   <= '0;
      r_buf_data   <= '0;
      r_buf_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_win_found) begin
        r_gid        <= w_win_id;
        r_saved_addr <= w_hit ? r_buf_addr : w_win_addr;
      end
      if (r_state == S_WAIT && i_mem_resp_valid) begin
        r_buf_data  <= i_mem_resp_data;
        r_buf_addr  <= r_saved_addr;
        r_buf_valid <= 1'b1;
      end
      if (r_state == S_HOLD) begin
        r_rr_ptr <= (r_gid == IdW'(N_PORTS - 1)) ? '0 : r_gid + IdW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Scoreboard bench for cache_refill_arbiter: a memory model answers requests, a monitor
// pops expected memory addresses and grants as the DUT produces them.
module tb_cache_refill_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int BW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    tb_req_valid;
  logic [N*AW-1:0] tb_req_addr;
  logic [N-1:0]    o_req_ready;
  logic [BW-1:0]   o_req_data;
  logic            o_mem_req_valid;
  logic [AW-1:0]   o_mem_req_addr;
  logic            i_mem_req_ready;
  logic            i_mem_resp_valid;
  logic [BW-1:0]   i_mem_resp_data;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
  } gnt_t;

  logic [AW-1:0] exp_mem_q[$];
  gnt_t          exp_gnt_q[$];

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            mem_count = 0;
  int            stall_until = 0;
  int            force_cyc = -1;
  bit            resp_en = 1'b1;
  bit            hs_flag = 1'b0;
  logic [AW-1:0] hs_addr = '0;

  always #5 clk = ~clk;

  cache_refill_arbiter #(
    .N_PORTS    (N),
    .ADDR_WIDTH (AW),
    .BLOCK_WIDTH(BW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_valid     (tb_req_valid),
    .i_req_addr      (tb_req_addr),
    .o_req_ready     (o_req_ready),
    .o_req_data      (o_req_data),
    .o_mem_req_valid (o_mem_req_valid),
    .o_mem_req_addr  (o_mem_req_addr),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_data (i_mem_resp_data)
  );

  function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
    logic [AW-1:0] inc;
    inc = a + 12'h003;
    return {a, ~a, a ^ 12'h5A5, inc, 16'hBEEF};
  endfunction

  // Memory: ready unless stalled, answers the cycle after an accepted request.
  task automatic mem_model();
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      i_mem_req_ready  = (cyc >= stall_until);
      i_mem_resp_valid = (hs_flag && resp_en) || (cyc == force_cyc);
      i_mem_resp_data  = i_mem_resp_valid ? blk(hs_flag ? hs_addr : 12'hDEA) : '0;
    end
  endtask

  task automatic monitor();
    bit            hold_chk = 1'b0;
    logic [BW-1:0] hold_data = '0;
    logic [AW-1:0] ea;
    logic [N-1:0]  er;
    gnt_t          g;
    forever begin
      @(negedge clk);
      hs_flag = o_mem_req_valid && i_mem_req_ready && !rst;
      hs_addr = o_mem_req_addr;
      if (hs_flag) begin
        mem_count++;
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_req unexpected: got addr %h, required none", o_mem_req_addr);
        end else begin
          ea = exp_mem_q.pop_front();
          if (o_mem_req_addr !== ea) begin
            errors++;
            $display("FAIL mem_req_addr: got %h, required %h", o_mem_req_addr, ea);
          end
        end
      end
      if (hold_chk) begin
        checks++;
        if (o_req_data !== hold_data) begin
          errors++;
          $display("FAIL req_data_hold: got %h, required %h", o_req_data, hold_data);
        end
      end
      hold_chk = 1'b0;
      if (o_req_ready !== '0) begin
        checks++;
        if (exp_gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant unexpected: got ready %b, required 0000", o_req_ready);
        end else begin
          g      = exp_gnt_q.pop_front();
          er     = '0;
          er[g.port] = 1'b1;
          if (o_req_ready !== er || o_req_data !== blk(g.addr)) begin
            errors++;
            $display("FAIL grant: got ready %b data %h, required ready %b data %h",
                     o_req_ready, o_req_data, er, blk(g.addr));
          end
          hold_chk  = 1'b1;
          hold_data = blk(g.addr);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a);
    tb_req_valid[p]          = 1'b1;
    tb_req_addr[p*AW +: AW]  = a;
  endtask

  task automatic push(input int p, input logic [AW-1:0] a, input bit to_mem);
    gnt_t g;
    g.port = p;
    g.addr = a;
    exp_gnt_q.push_back(g);
    if (to_mem) exp_mem_q.push_back(a);
  endtask

  // Requesters drop req_valid the cycle after they see req_ready.
  task automatic run_until_idle(input int budget, output int first_cyc, output int last_cyc);
    logic [N-1:0] drop;
    bit           done;
    done      = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      drop = o_req_ready;
      if (drop != '0) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
      @(posedge clk);
      #1;
      tb_req_valid = tb_req_valid & ~drop;
      if (tb_req_valid == '0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL run_timeout: got pending %b after %0d cycles, required 0000",
               tb_req_valid, budget);
      tb_req_valid = '0;
    end
    idle(3);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    tb_req_valid = '0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    tb_req_valid = '0;
    idle(1);
    @(negedge clk);
    checks++;
    if (o_req_ready !== '0 || o_mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready %b mem_valid %b, required 0000 0",
               o_req_ready, o_mem_req_valid);
    end
    checks++;
    if (o_mem_req_addr !== '0 || o_req_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr %h data %h, required 0 0", o_mem_req_addr, o_req_data);
    end
    idle(1);
    rst = 1'b0;
  endtask

  task automatic test_single_miss();
    int f, l;
    do_reset();
    set_req(1, 12'h0A5);
    push(1, 12'h0A5, 1'b1);
    run_until_idle(30, f, l);
    checks++;
    if (f != 3) begin
      errors++;
      $display("FAIL miss_latency: got %0d, required 3", f);
    end
  endtask

  task automatic test_rr_order();
    int f, l;
    do_reset();
    set_req(0, 12'h011);
    set_req(2, 12'h022);
    set_req(3, 12'h033);
    push(0, 12'h011, 1'b1);
    push(2, 12'h022, 1'b1);
    push(3, 12'h033, 1'b1);
    run_until_idle(60, f, l);
    // rr_ptr wrapped to 0 after port 3, so port 0 beats port 1.
    set_req(1, 12'h044);
    set_req(0, 12'h055);
    push(0, 12'h055, 1'b1);
    push(1, 12'h044, 1'b1);
    run_until_idle(60, f, l);
  endtask

  task automatic test_same_block();
    int f, l, mc;
    do_reset();
    mc = mem_count;
    set_req(1, 12'h100);
    set_req(3, 12'h100);
    push(1, 12'h100, 1'b1);
    push(3, 12'h100, 1'b0);
    run_until_idle(40, f, l);
    checks++;
    if (mem_count - mc != 1) begin
      errors++;
      $display("FAIL same_block_mem_count: got %0d, required 1", mem_count - mc);
    end
    checks++;
    if (l - f != 3) begin
      errors++;
      $display("FAIL buffer_hit_gap: got %0d, required 3", l - f);
    end
  endtask

  task automatic test_mem_stall();
    int f, l;
    do_reset();
    stall_until = cyc + 6;
    set_req(0, 12'h3C3);
    push(0, 12'h3C3, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (c >= 1 && (o_mem_req_valid !== 1'b1 || o_mem_req_addr !== 12'h3C3
                     || o_req_ready !== '0)) begin
        errors++;
        $display("FAIL stall_hold c%0d: got valid %b addr %h ready %b, required 1 3c3 0000",
                 c, o_mem_req_valid, o_mem_req_addr, o_req_ready);
      end else if (c == 0 && o_req_ready !== '0) begin
        errors++;
        $display("FAIL stall_idle: got ready %b, required 0000", o_req_ready);
      end
    end
    run_until_idle(30, f, l);
  endtask

  task automatic test_drop_in_wait();
    int f, l, mc;
    do_reset();
    set_req(2, 12'h2B2);
    exp_mem_q.push_back(12'h2B2);
    idle(1);
    idle(1);
    tb_req_valid[2] = 1'b0;
    idle(6);
    mc = mem_count;
    set_req(0, 12'h2B2);
    push(0, 12'h2B2, 1'b0);
    run_until_idle(20, f, l);
    checks++;
    if (mem_count != mc) begin
      errors++;
      $display("FAIL drop_rehit_mem: got %0d requests, required 0", mem_count - mc);
    end
  endtask

  task automatic test_reset_in_wait();
    int f, l, mc;
    resp_en = 1'b0;
    set_req(1, 12'h0F0);
    exp_mem_q.push_back(12'h0F0);
    idle(1);
    idle(1);
    rst          = 1'b1;
    tb_req_valid = '0;
    idle(1);
    rst       = 1'b0;
    force_cyc = cyc + 1;
    @(negedge clk);
    checks++;
    if (o_req_ready !== '0 || o_mem_req_valid !== 1'b0 || o_mem_req_addr !== '0
        || o_req_data !== '0) begin
      errors++;
      $display("FAIL rst_in_wait: got ready %b valid %b addr %h data %h, required all 0",
               o_req_ready, o_mem_req_valid, o_mem_req_addr, o_req_data);
    end
    idle(5);
    @(negedge clk);
    checks++;
    if (o_req_data !== '0 || o_req_ready !== '0) begin
      errors++;
      $display("FAIL stale_resp: got data %h ready %b, required 0 0000", o_req_data, o_req_ready);
    end
    resp_en = 1'b1;
    idle(1);
    // Buffer held 0x2B2 before reset; it must now miss.
    mc = mem_count;
    set_req(0, 12'h2B2);
    push(0, 12'h2B2, 1'b1);
    run_until_idle(30, f, l);
    checks++;
    if (mem_count - mc != 1) begin
      errors++;
      $display("FAIL rst_drops_buffer: got %0d requests, required 1", mem_count - mc);
    end
  endtask

  initial begin
    rst              = 1'b1;
    tb_req_valid     = '0;
    tb_req_addr      = '0;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_resp_data  = '0;
    fork
      mem_model();
      monitor();
    join_none
    test_reset();
    test_single_miss();
    test_rr_order();
    test_same_block();
    test_mem_stall();
    test_drop_in_wait();
    test_reset_in_wait();
    idle(5);
    checks++;
    if (exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL mem_queue_left: got %0d entries, required 0", exp_mem_q.size());
    end
    checks++;
    if (exp_gnt_q.size() != 0) begin
      errors++;
      $display("FAIL grant_queue_left: got %0d entries, required 0", exp_gnt_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
